// File: rtl/conv2d_systolic_engine.sv
// Output-stationary systolic engine for 2-D valid convolution of an NxN tile with a KxK filter.
// A diagonal wavefront of PEs accumulates all MxM outputs; weights hop one PE per cycle.
module conv2d_systolic_engine #(
    parameter int N  = 4,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           sat_en,
    input  logic [N*N*DW-1:0]              zin,
    input  logic [K*K*DW-1:0]              filter,
    output logic [(N-K+1)*(N-K+1)*AW-1:0]  out,
    output logic                           out_valid,
    output logic                           done,
    output logic                           busy,
    output logic [2:0]                     state
);

    localparam int M  = N - K + 1;
    localparam int KK = K * K;
    localparam int R  = KK + 2 * (M - 1);
    localparam int CW = $clog2(R + 1);
    localparam logic [AW-1:0] SATMAX = AW'((1 << DW) - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3
    } state_t;

    state_t                st, st_nxt;
    logic [CW-1:0]         cnt;
    logic [N*N*DW-1:0]     zin_q;
    logic [KK*DW-1:0]      filt_q;
    logic                  sat_q;
    logic                  last;
    logic [DW-1:0]         w00;
    logic [M*M*AW-1:0]     out_nxt;

    assign last  = (st == RUN) && (cnt == CW'(R - 1));
    assign done  = (st == DONE);
    assign busy  = (st != IDLE);
    assign state = st;

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (start) st_nxt = LOAD;
            LOAD:    st_nxt = RUN;
            RUN:     if (last) st_nxt = DONE;
            DONE:    st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // The final products land on the same edge that enters DONE, so out is
    // taken from the next-accumulator values to be valid during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            zin_q     <= '0;
            filt_q    <= '0;
            sat_q     <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            st <= st_nxt;
            if (st == IDLE && start) begin
                zin_q     <= zin;
                filt_q    <= filter;
                sat_q     <= sat_en;
                out_valid <= 1'b0;
            end
            if (st == LOAD) begin
                cnt <= '0;
            end else if (st == RUN) begin
                cnt <= cnt + CW'(1);
            end
            if (last) begin
                out       <= out_nxt;
                out_valid <= 1'b1;
            end
        end
    end

    // Weight injected into the corner PE; everything downstream sees it delayed by i+j hops.
    always_comb begin
        w00 = '0;
        for (int tt = 0; tt < KK; tt++) begin
            if (cnt == CW'(tt)) w00 = filt_q[tt*DW +: DW];
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < M; j++) begin : g_col
            logic [DW-1:0]   wcur;
            logic [DW-1:0]   zsel;
            logic            act;
            logic [2*DW-1:0] prod;
            logic [AW-1:0]   acc;
            logic [AW-1:0]   acc_nxt;

            if (i == 0 && j == 0) begin : g_src
                assign wcur = w00;
            end else if (j > 0) begin : g_src
                assign wcur = g_row[i].g_col[j-1].g_fwd.wreg;
            end else begin : g_src
                assign wcur = g_row[i-1].g_col[0].g_fwd.wreg;
            end

            always_comb begin
                act  = 1'b0;
                zsel = '0;
                for (int tt = 0; tt < KK; tt++) begin
                    if (st == RUN && cnt == CW'(tt + i + j)) begin
                        act  = 1'b1;
                        zsel = zin_q[((i + tt / K) * N + j + tt % K) * DW +: DW];
                    end
                end
            end

            assign prod    = {{DW{1'b0}}, zsel} * {{DW{1'b0}}, wcur};
            assign acc_nxt = act ? acc + AW'(prod) : acc;
            assign out_nxt[(i*M+j)*AW +: AW] = (sat_q && acc_nxt > SATMAX) ? SATMAX : acc_nxt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc <= '0;
                end else if (st == LOAD) begin
                    acc <= '0;
                end else if (st == RUN) begin
                    acc <= acc_nxt;
                end
            end

            // Only PEs that feed a neighbour keep a forwarding register.
            if (j < M - 1 || (j == 0 && i < M - 1)) begin : g_fwd
                logic [DW-1:0] wreg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        wreg <= '0;
                    end else if (st == LOAD) begin
                        wreg <= '0;
                    end else if (st == RUN) begin
                        wreg <= wcur;
                    end
                end
            end
        end
    end

endmodule

// File: doc/conv2d_systolic_engine.md
# conv2d_systolic_engine

Parametrised output-stationary systolic engine for 2-D valid convolution of an N×N unsigned input tile with a K×K unsigned filter. It produces all M×M outputs (M = N−K+1) at full accumulator width, with an optional saturating output mode and a start/done handshake. It is the generalised successor of the fixed 4×4 / 3×3 / four-output systolic array and sits between the tile buffer and the post-processing stage.

## Interface
- N, 4: input tile dimension (N ≥ 2)
- K, 3: filter dimension (1 ≤ K ≤ N)
- DW, 8: data and filter element width, unsigned
- AW, 20: accumulator/output element width; must be ≥ 2·DW
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a convolution; sampled only in IDLE
- sat_en  in  1  1 = clamp each output to 2^DW−1; captured with start
- zin  in  N·N·DW  element (r,c) at bits [(r·N+c)·DW +: DW]
- filter  in  K·K·DW  element (r,c) at bits [(r·K+c)·DW +: DW]
- out  out  M·M·AW  output (i,j) at bits [(i·M+j)·AW +: AW]
- out_valid  out  1  out holds a completed result
- done  out  1  one-cycle pulse on completion
- busy  out  1  state ≠ IDLE
- state  out  3  IDLE=0, LOAD=1, RUN=2, DONE=3

## Operation
- Reset: state=IDLE, out=0, out_valid=0, done=0, busy=0, all internal registers 0. Reset mid-run aborts the operation and produces no done.
- IDLE: when start=1, capture zin, filter, and sat_en on that edge, then go to LOAD. zin and filter may change freely afterwards.
- LOAD (1 cycle): clear all M×M accumulators, clear out_valid, clear the run counter cnt, then go to RUN.
- RUN: cnt runs from 0 to R−1, with R = K·K + 2(M−1).
  - PE(i,j) is active when t = cnt−(i+j) lies in [0, K·K−1]. This is a diagonal wavefront.
  - An active PE decodes kr = t/K and kc = t%K, and adds zin[i+kr][j+kc]·filter[kr][kc] to its accumulator.
  - Weights travel systolically: each PE receives the weight registered one hop from its upstream neighbour.
  - At cnt = R−1, go to DONE.
- DONE (1 cycle): register out from the accumulators, or their saturated values when sat_en=1. Set out_valid=1, pulse done=1, then return to IDLE.
- out and out_valid hold until the next start is accepted; out_valid drops on entry to LOAD.
- start is ignored in LOAD, RUN, and DONE. A start held high in DONE is not accepted until the IDLE cycle that follows.
- Arithmetic:
  - Products are unsigned DW×DW → 2·DW bits, zero-extended to AW.
  - Accumulation wraps modulo 2^AW. No overflow flag.
  - Saturation compares the full AW-bit sum against 2^DW−1.

## Timing
- Latency: done goes high L = R+1 rising edges after the edge that accepts start (default L = 12).
- For N=5, K=3: M=3, R=13, L=14.
- Minimum start-to-start period: L+1 edges, because one IDLE cycle is required after DONE.
- busy is high from the edge after start acceptance through the DONE cycle.
- done and out_valid both rise in the DONE cycle. done falls on the next edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Default parameters, zin rows {1,7,0,2}/{2,2,1,4}/{3,6,7,5}/{4,4,2,3}, filter rows {4,6,1}/{3,5,8}/{5,9,2}, sat_en=0, start pulse:
  - done occurs exactly 12 edges after acceptance.
  - out(0,0)=153, out(0,1)=176, out(1,0)=176, out(1,1)=155.
  - state sequence 0→1→2(×11)→3→0.
- All zin and filter elements = 255:
  - sat_en=0 gives every out = 585225.
  - Repeating with sat_en=1 gives every out = 255.
- Change zin and filter, and pulse start, during RUN of the first test's operation:
  - start is ignored and the results are unchanged (153/176/176/155).
  - A start issued after the IDLE cycle returns to IDLE computes from the new values.
- Assert rst in the middle of RUN (cnt=5):
  - Immediately: state=0, out=0, busy=0, out_valid=0.
  - No done pulse follows. A fresh start afterwards yields the correct results.
- Back-to-back runs with start held high:
  - done pulses are spaced exactly 13 edges apart.
  - out_valid drops for the LOAD/RUN period between pulses.
- N=5, K=3, zin(r,c)=r+c, filter all 1:
  - out(i,j) = 9·(i+j+2), so out(0,0)=18 and out(2,2)=54.
  - done occurs 14 edges after acceptance.
